// File: rtl/mem_arbiter.sv
// Purpose: arbitrates one single-port RAM between instruction fetch and data load/store.
// Latency: one IDLE arbitration cycle, then the grant holds until ramstate reports ACCESS.
// Backpressure: the requester that is not granted sees wait=1; a hung grant is ended by a watchdog.
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 8,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2,
        ERRC = 2'd3
    } state_t;

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
    } ram_req_t;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    state_t           state, state_nxt;
    logic             last_d, last_d_nxt;
    logic             err_d, err_d_nxt;
    logic [CNT_W-1:0] wdog;
    ram_req_t         req;

    logic d_pend, access, rerr, timeout, in_grant;

    assign d_pend   = dREN | dWEN;
    assign access   = (ramstate == RS_ACCESS);
    assign rerr     = (ramstate == RS_ERROR);
    assign timeout  = (wdog == CNT_W'(TIMEOUT));
    assign in_grant = (state == IGNT) || (state == DGNT);

    // State register plus the arbitration history, watchdog and sticky error.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            err_d   <= 1'b0;
            wdog    <= '0;
            mem_err <= 1'b0;
        end else begin
            state  <= state_nxt;
            last_d <= last_d_nxt;
            err_d  <= err_d_nxt;
            if (!in_grant) begin
                wdog <= '0;
            end else if (!access && (wdog != {CNT_W{1'b1}})) begin
                wdog <= wdog + CNT_W'(1);
            end
            if (state_nxt == ERRC) begin
                mem_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        last_d_nxt = last_d;
        err_d_nxt  = err_d;
        case (state)
            IDLE: begin
                if (d_pend && (!iREN || !last_d)) begin
                    state_nxt = DGNT;
                end else if (iREN) begin
                    state_nxt = IGNT;
                end
            end
            DGNT: begin
                if (!d_pend) begin
                    state_nxt = IDLE;
                end else if (access) begin
                    state_nxt  = IDLE;
                    last_d_nxt = 1'b1;
                end else if (rerr || timeout) begin
                    state_nxt = ERRC;
                    err_d_nxt = 1'b1;
                end
            end
            IGNT: begin
                if (!iREN) begin
                    state_nxt = IDLE;
                end else if (access) begin
                    state_nxt  = IDLE;
                    last_d_nxt = 1'b0;
                end else if (rerr || timeout) begin
                    state_nxt = ERRC;
                    err_d_nxt = 1'b0;
                end
            end
            ERRC: begin
                state_nxt  = IDLE;
                last_d_nxt = err_d;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Enables follow the live request so a requester that gives up frees the RAM at once.
    always_comb begin
        req   = '0;
        iwait = 1'b0;
        dwait = 1'b0;
        iload = '0;
        dload = '0;
        case (state)
            IDLE: begin
                iwait = iREN;
                dwait = d_pend;
            end
            DGNT: begin
                req.ren   = dREN & ~dWEN;
                req.wen   = dWEN;
                req.addr  = daddr;
                req.store = dstore;
                iwait     = iREN;
                dwait     = d_pend & ~access;
                if (d_pend && access) begin
                    dload = ramload;
                end
            end
            IGNT: begin
                req.ren  = iREN;
                req.addr = iaddr;
                iwait    = iREN & ~access;
                dwait    = d_pend;
                if (iREN && access) begin
                    iload = ramload;
                end
            end
            ERRC: begin
                if (err_d) begin
                    dload = ERR_WORD;
                    iwait = iREN;
                end else begin
                    iload = ERR_WORD;
                    dwait = d_pend;
                end
            end
            default: begin
                req = '0;
            end
        endcase
    end

    assign ramREN   = req.ren;
    assign ramWEN   = req.wen;
    assign ramaddr  = req.addr;
    assign ramstore = req.store;

endmodule
